mcs4_rom_ctrl: RTL and testbench
================================

// Module: mcs4_rom_ctrl
// PURPOSE
//  Program-memory controller for the i4004 multiplexed 4-bit bus; emulates 4001 ROM fetch timing.
//  Tracks the 8-phase cycle from sync and captures the 12-bit address over A1..A3.
//  Drives OPR/OPA on M1/M2 from internal byte storage.
//  Arbitrates the single-port storage between CPU fetches and a host (PS-side) write port used for program load.
// PARAMETERS
//  Base_page  4'h0  first 256-byte page served (addr[11:8])
//  Num_pages  16    pages served; storage depth = Num_pages*256 bytes (1..16)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous, active-high reset
//  sync         in   1   i4004 sync; high during X3, so the next cycle is A1
//  cm_rom       in   1   i4004 ROM command line
//  dbus_in      in   4   nibble driven by CPU (address in A1..A3)
//  dbus_out     out  4   nibble driven to CPU (OPR in M1, OPA in M2)
//  dbus_oe      out  1   high when dbus_out is valid for the CPU
//  host_wvalid  in   1   host write request
//  host_wready  out  1   host write accepted this cycle (valid & ready = transfer)
//  host_waddr   in   12  absolute byte address of host write
//  host_wdata   in   8   byte to store
//  fetch_addr   out  12  last captured fetch address
//  fetch_hit    out  1   one-cycle pulse: fetch served by this block
//  sync_err     out  1   sticky: sync missing or early vs. phase count; cleared by rst
// BEHAVIOUR
//  Reset (async): phase=SEEK. dbus_out=0, dbus_oe=0, host_wready=0, fetch_addr=0, fetch_hit=0, sync_err=0.
//   Storage contents are not reset.
//  Phase FSM: SEEK,A1,A2,A3,M1,M2,X1,X2,X3.
//   SEEK->A1 on the cycle after sync=1. Otherwise advance one phase per clk; X3->A1.
//   In X3, sync must be 1. If it is 0, set sync_err and go to SEEK.
//   In any other non-SEEK phase, sync=1 sets sync_err and the next phase is A1 (resync).
//  Address capture: A1 latches addr[3:0], A2 latches addr[7:4], A3 latches addr[11:8] from dbus_in.
//  Hit = cm_rom high in A3 AND addr[11:8] in [Base_page, Base_page+Num_pages-1].
//   Page arithmetic is 5-bit, with no wrap past page 15.
//  On hit:
//   - The storage read is issued in A3 and the byte is registered.
//   - M1: dbus_out = byte[7:4], dbus_oe=1.
//   - M2: dbus_out = byte[3:0], dbus_oe=1.
//   - fetch_addr updates and fetch_hit pulses in M1.
//  On miss: dbus_oe=0, dbus_out=0 for all phases; fetch_addr is unchanged.
//  dbus_oe is 0 in every phase other than M1/M2.
//  Arbitration, single storage port, CPU priority:
//   - host_wready=0 in phase A3 (fetch read slot); 1 in all other phases, including SEEK.
//   - A write accepted in the cycle before A3 is visible to that A3 read (write-then-read order).
//   - Out-of-range host_waddr (page outside window): handshake completes, data is discarded.
//   - host_wvalid may stay high across A3; it is held off, then accepted in M1. No stall, no drop.
//  Reset mid-cycle: the FSM returns to SEEK, the bus is released immediately, and an in-flight fetch is abandoned.
//  Latency: address complete at A3 -> OPR on the bus 1 clk later (M1).
// TESTING
//  1 Host writes 0xD5 @0x000, then CPU fetch 0x000 with cm_rom=1 -> M1 dbus_out=0xD, M2=0x5, oe high 2 cycles, fetch_hit pulse.
//  2 Base_page=2, Num_pages=1: fetch 0x312 -> oe never high, fetch_addr unchanged; fetch 0x2FF -> data driven.
//  3 host_wvalid held high from X3 -> ready low only in A3; exactly one accept; write lands.
//  4 Host writes 0x3C @0x010 in A2, CPU fetches 0x010 in same cycle -> M1=0x3, M2=0xC (new data).
//  5 Suppress sync at one X3 -> sync_err=1, FSM in SEEK, oe=0 until resync; next sync -> fetches resume.
//  6 Assert rst during M1 of a hit -> dbus_oe drops asynchronously, host_wready=0, FSM restarts in SEEK.

Source files
------------

// File: rtl/mcs4_rom_ctrl.sv
// 4001-style program ROM for the i4004 multiplexed bus: tracks the 8-phase
// instruction cycle, serves OPR/OPA from local storage, and accepts host program loads.
//
// state | meaning
// SEEK  | waiting for sync to find cycle alignment
// A1-A3 | CPU drives address nibbles low, mid, high
// M1    | OPR (byte[7:4]) driven on a hit
// M2    | OPA (byte[3:0]) driven on a hit
// X1-X3 | execute phases; sync expected in X3
module mcs4_rom_ctrl #(
   parameter logic [3:0]  Base_page = 4'h0,
   parameter int unsigned Num_pages = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sync,
   input  logic        cm_rom,
   input  logic [3:0]  dbus_in,
   output logic [3:0]  dbus_out,
   output logic        dbus_oe,
   input  logic        host_wvalid,
   output logic        host_wready,
   input  logic [11:0] host_waddr,
   input  logic [7:0]  host_wdata,
   output logic [11:0] fetch_addr,
   output logic        fetch_hit,
   output logic        sync_err
);
   localparam int unsigned Depth = Num_pages * 256;
   localparam int unsigned Iw    = $clog2(Depth);
   localparam logic [4:0]  PgLo  = {1'b0, Base_page};
   localparam logic [4:0]  NumPg = 5'(Num_pages);

   typedef enum logic [3:0] {SEEK, A1, A2, A3, M1, M2, X1, X2, X3} phase_e;

   phase_e      phase_q, phase_d;
   logic        sync_err_q, sync_err_d;
   logic [7:0]  addr_lo_q;
   logic [11:0] fetch_addr_q;
   logic        hit_q;
   logic [7:0]  rd_q;
   logic [7:0]  mem [Depth];

   logic           a3_hit;
   logic           wr_en;
   logic [Iw-1:0]  rd_idx, wr_idx;

   // Pages below the base wrap to a large relative value, so one compare covers both ends.
   function automatic logic in_window(input logic [3:0] pg);
      logic [4:0] rel;
      rel = {1'b0, pg} - PgLo;
      return rel < NumPg;
   endfunction

   function automatic logic [Iw-1:0] mem_idx(input logic [11:0] a);
      logic [11:0] off;
      off = a - {Base_page, 8'h00};
      return off[Iw-1:0];
   endfunction

   always_comb begin
      phase_d    = phase_q;
      sync_err_d = sync_err_q;
      case (phase_q)
         SEEK:    phase_d = sync ? A1 : SEEK;
         A1:      phase_d = A2;
         A2:      phase_d = A3;
         A3:      phase_d = M1;
         M1:      phase_d = M2;
         M2:      phase_d = X1;
         X1:      phase_d = X2;
         X2:      phase_d = X3;
         X3:      phase_d = sync ? A1 : SEEK;
         default: phase_d = SEEK;
      endcase
      if (phase_q == X3 && !sync) begin
         sync_err_d = 1'b1;
      end
      if (phase_q != SEEK && phase_q != X3 && sync) begin
         phase_d    = A1;
         sync_err_d = 1'b1;
      end
   end

   // A resync landing in A3 abandons the fetch, so it never claims the bus.
   always_comb begin
      a3_hit = (phase_q == A3) && cm_rom && !sync && in_window(dbus_in);
      rd_idx = mem_idx({dbus_in, addr_lo_q});
      wr_en  = host_wvalid && host_wready && in_window(host_waddr[11:8]);
      wr_idx = mem_idx(host_waddr);
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= host_wdata;
      end
      if (a3_hit) begin
         rd_q <= mem[rd_idx];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q      <= SEEK;
         sync_err_q   <= 1'b0;
         addr_lo_q    <= 8'h00;
         fetch_addr_q <= 12'h000;
         hit_q        <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         sync_err_q <= sync_err_d;
         if (phase_q == A1) begin
            addr_lo_q[3:0] <= dbus_in;
         end
         if (phase_q == A2) begin
            addr_lo_q[7:4] <= dbus_in;
         end
         if (phase_q == A3) begin
            hit_q <= a3_hit;
            if (a3_hit) begin
               fetch_addr_q <= {dbus_in, addr_lo_q};
            end
         end
      end
   end

   always_comb begin
      dbus_out = 4'h0;
      dbus_oe  = 1'b0;
      if (hit_q && phase_q == M1) begin
         dbus_oe  = 1'b1;
         dbus_out = rd_q[7:4];
      end else if (hit_q && phase_q == M2) begin
         dbus_oe  = 1'b1;
         dbus_out = rd_q[3:0];
      end
   end

   assign host_wready = !rst && (phase_q != A3);
   assign fetch_hit   = hit_q && (phase_q == M1);
   assign fetch_addr  = fetch_addr_q;
   assign sync_err    = sync_err_q;
endmodule

// File: tb/tb_mcs4_rom_ctrl.sv
// Bench for mcs4_rom_ctrl: a full-window and a one-page-window instance share the
// same bus; a byte-array model predicts fetched data and a scoreboard checks the bus.
module tb_mcs4_rom_ctrl;
   localparam int WB = 2;
   localparam int WN = 1;

   logic        clk, rst, sync, cm_rom, host_wvalid;
   logic [3:0]  dbus_in;
   logic [11:0] host_waddr;
   logic [7:0]  host_wdata;

   logic [3:0]  f_out, w_out;
   logic        f_oe, w_oe, f_wready, w_wready, f_hit, w_hit, f_err, w_err;
   logic [11:0] f_fa, w_fa;

   mcs4_rom_ctrl u_full (
      .clk(clk), .rst(rst), .sync(sync), .cm_rom(cm_rom), .dbus_in(dbus_in),
      .dbus_out(f_out), .dbus_oe(f_oe), .host_wvalid(host_wvalid), .host_wready(f_wready),
      .host_waddr(host_waddr), .host_wdata(host_wdata), .fetch_addr(f_fa),
      .fetch_hit(f_hit), .sync_err(f_err));

   mcs4_rom_ctrl #(.Base_page(4'(WB)), .Num_pages(WN)) u_win (
      .clk(clk), .rst(rst), .sync(sync), .cm_rom(cm_rom), .dbus_in(dbus_in),
      .dbus_out(w_out), .dbus_oe(w_oe), .host_wvalid(host_wvalid), .host_wready(w_wready),
      .host_waddr(host_waddr), .host_wdata(host_wdata), .fetch_addr(w_fa),
      .fetch_hit(w_hit), .sync_err(w_err));

   typedef struct packed {
      logic [7:0]  data;
      logic [11:0] addr;
   } exp_t;

   exp_t        q_full[$], q_win[$];
   exp_t        cur_f, cur_w;
   logic [7:0]  mem_m [4096];
   logic [11:0] exp_fa_full, exp_fa_win;
   bit          exp_a3, m2_f, m2_w;
   int          n_checks, n_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
      end
   endtask

   task automatic flag(input string nm);
      n_checks++;
      n_err++;
      $display("FAIL %s at %0t", nm, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit win_hit(input logic [11:0] a);
      int pg;
      pg = int'(a[11:8]);
      return (pg >= WB) && (pg <= WB + WN - 1);
   endfunction

   // Model storage follows every write the bench expects the controller to accept.
   always @(negedge clk) begin
      if (!rst) begin
         chk("wready_full", 32'(f_wready), 32'(!exp_a3));
         chk("wready_win", 32'(w_wready), 32'(!exp_a3));
         if (host_wvalid && !exp_a3) mem_m[host_waddr] = host_wdata;
      end
   end

   always @(negedge clk) begin
      if (rst) m2_f = 1'b0;
      else if (f_oe) begin
         if (!m2_f) begin
            if (q_full.size() == 0) flag("full_unexpected_oe");
            else begin
               cur_f = q_full.pop_front();
               chk("full_opr", 32'(f_out), 32'(cur_f.data[7:4]));
               chk("full_hit_m1", 32'(f_hit), 32'd1);
               chk("full_faddr_m1", 32'(f_fa), 32'(cur_f.addr));
            end
            m2_f = 1'b1;
         end else begin
            chk("full_opa", 32'(f_out), 32'(cur_f.data[3:0]));
            chk("full_hit_m2", 32'(f_hit), 32'd0);
            m2_f = 1'b0;
         end
      end else begin
         if (m2_f) flag("full_oe_short");
         m2_f = 1'b0;
         chk("full_out_idle", 32'(f_out), 32'd0);
         chk("full_hit_idle", 32'(f_hit), 32'd0);
      end
   end

   always @(negedge clk) begin
      if (rst) m2_w = 1'b0;
      else if (w_oe) begin
         if (!m2_w) begin
            if (q_win.size() == 0) flag("win_unexpected_oe");
            else begin
               cur_w = q_win.pop_front();
               chk("win_opr", 32'(w_out), 32'(cur_w.data[7:4]));
               chk("win_hit_m1", 32'(w_hit), 32'd1);
               chk("win_faddr_m1", 32'(w_fa), 32'(cur_w.addr));
            end
            m2_w = 1'b1;
         end else begin
            chk("win_opa", 32'(w_out), 32'(cur_w.data[3:0]));
            chk("win_hit_m2", 32'(w_hit), 32'd0);
            m2_w = 1'b0;
         end
      end else begin
         if (m2_w) flag("win_oe_short");
         m2_w = 1'b0;
         chk("win_out_idle", 32'(w_out), 32'd0);
         chk("win_hit_idle", 32'(w_hit), 32'd0);
      end
   end

   // Called at A1; returns at the following A1 (or SEEK when sync is withheld in X3).
   task automatic instr(input logic [11:0] a, input logic cm, input logic good_sync);
      sync = 1'b0; cm_rom = 1'b0; dbus_in = a[3:0]; tick();
      dbus_in = a[7:4]; tick();
      dbus_in = a[11:8]; cm_rom = cm; exp_a3 = 1'b1;
      if (cm) begin
         q_full.push_back(exp_t'{data: mem_m[a], addr: a});
         exp_fa_full = a;
      end
      if (cm && win_hit(a)) begin
         q_win.push_back(exp_t'{data: mem_m[a], addr: a});
         exp_fa_win = a;
      end
      tick();
      exp_a3 = 1'b0; cm_rom = 1'b0; dbus_in = 4'h0;
      repeat (4) tick();
      sync = good_sync; tick();
      sync = 1'b0;
      chk("fetch_addr_full", 32'(f_fa), 32'(exp_fa_full));
      chk("fetch_addr_win", 32'(w_fa), 32'(exp_fa_win));
   endtask

   task automatic host_put(input logic [11:0] a, input logic [7:0] d, output int waited);
      host_wvalid = 1'b1; host_waddr = a; host_wdata = d; waited = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (f_wready) break;
         waited++;
      end
      if (waited >= 4) flag("host_write_timeout");
      @(posedge clk); #1;
      host_wvalid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0] a, wa;
      logic [7:0]  wd;
      logic        cm;
      int          w, d;

      n_checks = 0; n_err = 0;
      rst = 1'b0; sync = 1'b0; cm_rom = 1'b0; dbus_in = 4'h0;
      host_wvalid = 1'b0; host_waddr = 12'h0; host_wdata = 8'h0;
      exp_a3 = 1'b0; exp_fa_full = 12'h0; exp_fa_win = 12'h0;
      m2_f = 1'b0; m2_w = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("rst_oe", 32'(f_oe), 32'd0);
      chk("rst_out", 32'(f_out), 32'd0);
      chk("rst_wready", 32'(f_wready), 32'd0);
      chk("rst_faddr", 32'(f_fa), 32'd0);
      chk("rst_hit", 32'(f_hit), 32'd0);
      chk("rst_sync_err", 32'(f_err), 32'd0);
      tick(); tick();
      rst = 1'b0;

      for (int i = 0; i < 4096; i++) begin
         host_wvalid = 1'b1; host_waddr = 12'(i); host_wdata = 8'($urandom);
         tick();
      end
      host_wvalid = 1'b0;

      // Basic fetch after a host load
      host_put(12'h000, 8'hD5, w);
      sync = 1'b1; tick();
      instr(12'h000, 1'b1, 1'b1);

      // Window bounds: out-of-window page, then last byte of the window page
      instr(12'h312, 1'b1, 1'b1);
      instr(12'h2FF, 1'b1, 1'b1);
      instr(12'h2FF, 1'b0, 1'b1);

      // Host write raised in A3 is held off one cycle, then lands
      fork
         instr(12'h123, 1'b1, 1'b1);
         begin tick(); tick(); host_put(12'h123, 8'hA7, w); end
      join
      chk("wr_hold_a3", 32'(w), 32'd1);
      instr(12'h123, 1'b1, 1'b1);

      // Write in A2 is visible to the same cycle's fetch
      fork
         instr(12'h010, 1'b1, 1'b1);
         begin tick(); host_put(12'h010, 8'h3C, w); end
      join
      chk("wr_a2_wait", 32'(w), 32'd0);

      for (int i = 0; i < 150; i++) begin
         a = 12'($urandom);
         if ($urandom_range(1) == 1) a[11:8] = 4'(WB);
         cm = ($urandom_range(3) != 0);
         wa = ($urandom_range(1) == 1) ? a : 12'($urandom);
         wd = 8'($urandom);
         d = $urandom_range(6);
         fork
            instr(a, cm, 1'b1);
            begin repeat (d) tick(); host_put(wa, wd, w); end
         join
      end

      // Missing sync in X3
      instr(12'h2A0, 1'b1, 1'b0);
      chk("sync_err_full", 32'(f_err), 32'd1);
      chk("sync_err_win", 32'(w_err), 32'd1);
      repeat (3) tick();
      sync = 1'b1; tick();
      instr(12'h2B4, 1'b1, 1'b1);
      chk("sync_err_sticky", 32'(f_err), 32'd1);

      // Reset in M1 of a hit
      a = 12'h2C7;
      sync = 1'b0; dbus_in = a[3:0]; tick();
      dbus_in = a[7:4]; tick();
      dbus_in = a[11:8]; cm_rom = 1'b1; exp_a3 = 1'b1;
      q_full.push_back(exp_t'{data: mem_m[a], addr: a});
      q_win.push_back(exp_t'{data: mem_m[a], addr: a});
      tick();
      exp_a3 = 1'b0; cm_rom = 1'b0; dbus_in = 4'h0;
      #5 rst = 1'b1;
      #1;
      chk("rst_m1_oe_full", 32'(f_oe), 32'd0);
      chk("rst_m1_oe_win", 32'(w_oe), 32'd0);
      chk("rst_m1_wready", 32'(f_wready), 32'd0);
      exp_fa_full = 12'h0; exp_fa_win = 12'h0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_clears_err", 32'(f_err), 32'd0);
      chk("rst_clears_faddr", 32'(f_fa), 32'd0);
      repeat (3) tick();
      sync = 1'b1; tick();
      instr(12'h2C7, 1'b1, 1'b1);
      instr(12'h7E1, 1'b1, 1'b1);

      chk("q_full_drained", 32'(q_full.size()), 32'd0);
      chk("q_win_drained", 32'(q_win.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
